// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - bus-mapped 8N1 UART transmitter with a small transmit FIFO
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_port #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  BASE_ADDR    = 8'hFE
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_address,
  input  logic       i_addressEn,
  input  logic [7:0] i_writeData,
  input  logic       i_writeEn,
  input  logic       i_outEnable,
  output logic [7:0] o_readData,
  output logic       o_tx,
  output logic       o_busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [7:0]    STAT_ADDR = BASE_ADDR + 8'd1;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_CFG = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam logic PAR_CFG = 1'b0;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;

  logic empty, full, push, push_ok, pop, stat_sel, data_sel, baud_done;
  logic [7:0] head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FIFO_FULL);
  assign stat_sel  = (addr_q == STAT_ADDR);
  assign data_sel  = (addr_q == BASE_ADDR);
  assign baud_done = (baud_q == BAUD_LAST);
  assign head      = mem_q[rd_ptr_q];
  assign o_busy    = (state_q != IDLE) || !empty;

  assign o_readData = !i_outEnable ? 8'hzz :
                      stat_sel     ? {3'b000, PAR_CFG, ovf_q, state_q != IDLE, full, empty} :
                      data_sel     ? 8'h00 : 8'hzz;

  // Bus side: address latch, FIFO push and the sticky overflow flag.
  always_comb begin
    addr_d   = i_addressEn ? i_address : addr_q;
    push     = i_writeEn && data_sel;
    push_ok  = push && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_writeData;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (i_outEnable && stat_sel) begin
      ovf_d = 1'b0;
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // Line side: frame sequencer.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    pop     = 1'b0;
    o_tx    = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = ^head;
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        o_tx   = 1'b0;
        baud_d = baud_done ? '0 : baud_q + CW'(1);
        if (baud_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        o_tx   = shift_q[0];
        baud_d = baud_done ? '0 : baud_q + CW'(1);
        if (baud_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        o_tx   = par_q;
        baud_d = baud_done ? '0 : baud_q + CW'(1);
        if (baud_done) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        baud_d = baud_done ? '0 : baud_q + CW'(1);
        if (baud_done) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = ^head;
            bit_d   = 3'd0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      addr_q   <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      bit_q    <= 3'd0;
      baud_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - randomized bench for uart_tx_port against a line-waveform model
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_port;

  localparam int         C    = 4;
  localparam int         D    = 4;
  localparam logic [7:0] BASE = 8'hFE;
  localparam logic [7:0] STAT = 8'hFF;
  localparam logic [7:0] RELEASED = 8'hFF;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, aen, we, oe;
  logic [7:0] addr, wd;
  wire  [7:0] rdata;
  logic       tx, busy;

  // A released bus floats up to the pull value.
  pullup (rdata);

  uart_tx_port #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
    .i_clk(clk), .i_reset(rst), .i_address(addr), .i_addressEn(aen),
    .i_writeData(wd), .i_writeEn(we), .i_outEnable(oe),
    .o_readData(rdata), .o_tx(tx), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: bytes waiting, remaining per-cycle line levels of the frame on the wire.
  logic [7:0] fifo_m [$];
  logic       wave_m [$];
  logic [7:0] addr_m;
  logic       ovf_m;

  task automatic load_frame(input logic [7:0] b);
    wave_m.delete();
    repeat (C) wave_m.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (C) wave_m.push_back(b[i]);
    if (PAR) repeat (C) wave_m.push_back(^b);
    repeat (C) wave_m.push_back(1'b1);
  endtask

  task automatic model_edge();
    logic pop_m, push_m, ovf_ev;
    if (rst) begin
      fifo_m.delete();
      wave_m.delete();
      addr_m = 8'h00;
      ovf_m  = 1'b0;
    end else begin
      pop_m  = (wave_m.size() <= 1) && (fifo_m.size() > 0);
      push_m = we && (addr_m == BASE);
      ovf_ev = push_m && (fifo_m.size() == D) && !pop_m;
      if (pop_m) load_frame(fifo_m.pop_front());
      else if (wave_m.size() > 0) void'(wave_m.pop_front());
      if (push_m && !ovf_ev) fifo_m.push_back(wd);
      if (oe && addr_m == STAT) ovf_m = 1'b0;
      if (ovf_ev) ovf_m = 1'b1;
      if (aen) addr_m = addr;
    end
  endtask

  task automatic step();
    logic [7:0] exp_rd;
    logic       exp_tx, exp_busy;
    @(posedge clk);
    #1;
    model_edge();
    exp_tx   = (wave_m.size() > 0) ? wave_m[0] : 1'b1;
    exp_busy = (wave_m.size() > 0) || (fifo_m.size() > 0);
    if (oe && addr_m == STAT)
      exp_rd = {3'b000, PAR, ovf_m, wave_m.size() > 0, fifo_m.size() == D, fifo_m.size() == 0};
    else if (oe && addr_m == BASE)
      exp_rd = 8'h00;
    else
      exp_rd = RELEASED;
    check("tx", {7'b0, tx}, {7'b0, exp_tx});
    check("busy", {7'b0, busy}, {7'b0, exp_busy});
    check("rdata", rdata, exp_rd);
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic latch(input logic [7:0] a);
    addr = a; aen = 1'b1; step(); aen = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    wd = d; we = 1'b1; step(); we = 1'b0;
  endtask

  task automatic rd();
    oe = 1'b1; step(); oe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; aen = 1'b0; we = 1'b0; oe = 1'b0; addr = 8'h00; wd = 8'h00;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    latch(STAT); rd(); cyc(1);

    latch(BASE); wr(8'hA5); cyc(50);
    repeat (2) begin
      wr(8'($urandom)); cyc(50);
    end

    for (int i = 0; i < 5; i++) wr(8'($urandom));
    latch(STAT); rd();
    latch(BASE); wr(8'($urandom));
    latch(STAT); rd(); rd();
    cyc(6 * 50);

    latch(8'h10); wr(8'h3C);
    latch(STAT);  wr(8'hC3);
    cyc(10);

    latch(BASE); wr(8'($urandom));
    cyc(1 + C + 3 * C + 1);
    rst = 1'b1; step(); rst = 1'b0;
    latch(STAT); rd(); cyc(50);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(3))
        0: addr = BASE;
        1: addr = STAT;
        2: addr = 8'h10;
        default: addr = 8'($urandom);
      endcase
      aen = ($urandom_range(9) < 2);
      we  = ($urandom_range(9) < 3);
      oe  = ($urandom_range(9) < 2);
      rst = ($urandom_range(199) == 0);
      wd  = 8'($urandom);
      step();
    end
    rst = 1'b0; aen = 1'b0; we = 1'b0; oe = 1'b0;
    cyc(6 * 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
